// File: rtl/pwm_period_core.sv
// PWM period counter and duty comparator. The count is advanced through an
// external adder (cnt_q + step -> sum_in); duty/period are double-buffered.
module pwm_period_core #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] duty_in,
  input  logic [N-1:0] period_in,
  input  logic         load,
  input  logic [N-1:0] sum_in,
  output logic [N-1:0] cnt_q,
  output logic [N-1:0] step,
  output logic         pwm_out,
  output logic         period_end,
  output logic         upd_pending
);

  logic [N-1:0] duty_act, period_act;
  logic [N-1:0] duty_pnd, period_pnd;
  logic         wrap;
  logic         apply;

  assign step  = {{(N-1){1'b0}}, 1'b1};
  assign wrap  = en && (cnt_q == period_act);
  assign apply = wrap && (upd_pending || load);

  // Count register: the adder supplies cnt_q+1, so no local incrementer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : sum_in;
    end
  end

  // Pending registers capture every load, enabled or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_pnd    <= '0;
      period_pnd  <= '0;
      upd_pending <= 1'b0;
    end else begin
      if (load) begin
        duty_pnd   <= duty_in;
        period_pnd <= period_in;
      end
      if (apply)     upd_pending <= 1'b0;
      else if (load) upd_pending <= 1'b1;
    end
  end

  // A load landing on the wrap cycle bypasses the pending stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act   <= '0;
      period_act <= '1;
    end else if (apply) begin
      duty_act   <= load ? duty_in   : duty_pnd;
      period_act <= load ? period_in : period_pnd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      pwm_out    <= en && (cnt_q < duty_act);
      period_end <= wrap;
    end
  end

endmodule
